// File: rtl/ring_phase_monitor.sv
// Ring counter watchdog: checks one-hot rotation of the ring bus, reports phase,
// lock status, revolution ticks and step errors. All outputs are registered.
module ring_phase_monitor #(
    parameter int W           = 4,
    parameter int ROT_LEFT    = 1,
    parameter int LOCK_CYCLES = 4,
    parameter int REV_W       = 8,
    parameter int ERR_W       = 4,
    localparam int PW         = $clog2(W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [W-1:0]     ring_in,
    output logic [PW-1:0]    phase,
    output logic             onehot_ok,
    output logic             locked,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_count,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t           state, state_d;
    logic [GW-1:0]    good_cnt, good_cnt_d;
    logic [W-1:0]     prev;
    logic [W-1:0]     expected;
    logic             sample_oh, good;
    logic [PW-1:0]    phase_enc, phase_d;
    logic             rev_tick_d, step_err_d;
    logic [REV_W-1:0] rev_count_d;
    logic [ERR_W-1:0] err_count_d;

    assign expected  = (ROT_LEFT != 0) ? {prev[W-2:0], prev[W-1]} : {prev[0], prev[W-1:1]};
    assign sample_oh = $onehot(ring_in);
    assign good      = sample_oh && (ring_in == expected);

    always_comb begin
        phase_enc = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (ring_in[i]) phase_enc = PW'(i);
        end
    end

    // State register (clr acts as a synchronous reset of everything)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else if (clr) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_d;
            good_cnt <= good_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state;
        good_cnt_d = good_cnt;
        case (state)
            IDLE: begin
                if (sample_oh) begin
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end
            end
            TRACK: begin
                if (good) begin
                    good_cnt_d = good_cnt + 1'b1;
                    if (good_cnt == GW'(LOCK_CYCLES - 1)) state_d = LOCKED;
                end else begin
                    good_cnt_d = '0;
                    state_d    = sample_oh ? TRACK : IDLE;
                end
            end
            LOCKED: begin
                if (!good) begin
                    good_cnt_d = '0;
                    state_d    = sample_oh ? TRACK : IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                good_cnt_d = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        phase_d     = sample_oh ? phase_enc : '0;
        rev_tick_d  = (state == LOCKED) && good && ring_in[0];
        step_err_d  = (state == LOCKED) && !good;
        rev_count_d = rev_count + REV_W'(rev_tick_d);
        err_count_d = err_count;
        if (step_err_d && (err_count != '1)) err_count_d = err_count + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev      <= '0;
            phase     <= '0;
            onehot_ok <= 1'b0;
            locked    <= 1'b0;
            rev_tick  <= 1'b0;
            rev_count <= '0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else if (clr) begin
            prev      <= '0;
            phase     <= '0;
            onehot_ok <= 1'b0;
            locked    <= 1'b0;
            rev_tick  <= 1'b0;
            rev_count <= '0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            prev      <= ring_in;
            phase     <= phase_d;
            onehot_ok <= sample_oh;
            locked    <= (state_d == LOCKED);
            rev_tick  <= rev_tick_d;
            rev_count <= rev_count_d;
            step_err  <= step_err_d;
            err_count <= err_count_d;
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: driver pushes model predictions,
// monitor pops and compares one prediction per clock.
module tb_ring_phase_monitor;

    logic       clk = 1'b0;
    logic       reset, clr;
    logic [3:0] ring_in;
    logic [1:0] phase;
    logic       onehot_ok, locked, rev_tick, step_err;
    logic [7:0] rev_count;
    logic [3:0] err_count;

    ring_phase_monitor #(.W(4), .ROT_LEFT(1), .LOCK_CYCLES(4), .REV_W(8), .ERR_W(4)) dut (
        .clk(clk), .reset(reset), .clr(clr), .ring_in(ring_in),
        .phase(phase), .onehot_ok(onehot_ok), .locked(locked),
        .rev_tick(rev_tick), .rev_count(rev_count),
        .step_err(step_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic       oh;
        logic       lk;
        logic       tick;
        logic [7:0] rc;
        logic       err;
        logic [3:0] ec;
    } obs_t;

    obs_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: trace-level view (streak of consecutive correct rotations)
    logic [3:0] m_prev;
    int         m_streak;
    bit         m_locked;
    logic [7:0] m_rc;
    logic [3:0] m_ec;
    logic [3:0] cur;

    function automatic void model_reset();
        m_prev = 4'd0; m_streak = 0; m_locked = 1'b0; m_rc = 8'd0; m_ec = 4'd0;
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] v);
        int x;
        x = int'(v);
        return 4'(((x << 1) | (x >> 3)) & 15);
    endfunction

    function automatic obs_t model_step(input logic [3:0] r, input logic c);
        obs_t e;
        bit   oh, good, was;
        e = '0;
        if (c) begin
            model_reset();
            return e;
        end
        oh   = ($countones(r) == 1);
        good = oh && (r == rotl(m_prev));
        was  = m_locked;
        m_streak = good ? m_streak + 1 : 0;
        m_locked = (m_streak >= 4);
        e.tick = was && good && (r == 4'b0001);
        e.err  = was && !good;
        if (e.tick) m_rc = m_rc + 8'd1;
        if (e.err && m_ec != 4'd15) m_ec = m_ec + 4'd1;
        e.ph = oh ? 2'($clog2(r)) : 2'd0;
        e.oh = oh;
        e.lk = m_locked;
        e.rc = m_rc;
        e.ec = m_ec;
        m_prev = r;
        return e;
    endfunction

    function automatic obs_t dut_obs();
        return obs_t'({phase, onehot_ok, locked, rev_tick, rev_count, step_err, err_count});
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ph=%0d oh=%0b lk=%0b tick=%0b rc=%0d err=%0b ec=%0d, required ph=%0d oh=%0b lk=%0b tick=%0b rc=%0d err=%0b ec=%0d",
                     name, got.ph, got.oh, got.lk, got.tick, got.rc, got.err, got.ec,
                     exp.ph, exp.oh, exp.lk, exp.tick, exp.rc, exp.err, exp.ec);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic c);
        @(negedge clk);
        reset   = 1'b1;
        ring_in = r;
        clr     = c;
        expq.push_back(model_step(r, c));
    endtask

    task automatic rotate_n(input int n);
        for (int i = 0; i < n; i++) begin
            cur = rotl(cur);
            drive(cur, 1'b0);
        end
    endtask

    // Monitor
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check($sformatf("cycle%0d", cyc), dut_obs(), e);
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clr = 1'b0; ring_in = 4'b0010;
        #2 reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 check("reset_hold", dut_obs(), '0);

        // Release, then a one-cycle clear
        drive(4'b0010, 1'b1);

        // Lock sequence from phase 1
        cur = 4'b0010;
        drive(cur, 1'b0);
        rotate_n(4);
        // Revolutions while locked
        rotate_n(12);

        // Multi-hot injection while locked, then resume and relock
        drive(4'b0110, 1'b0);
        cur = 4'b0100;
        drive(cur, 1'b0);
        rotate_n(6);

        // Skip while locked
        cur = rotl(rotl(cur));
        drive(cur, 1'b0);
        rotate_n(6);

        // Repeated stuck samples after relock: error counter saturates
        for (int k = 0; k < 18; k++) begin
            rotate_n(5);
            drive(cur, 1'b0);
        end

        // Revolution counter wrap
        rotate_n(260 * 4);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 75)      cur = rotl(cur);
            else if (sel < 80) cur = cur;
            else if (sel < 85) cur = rotl(rotl(cur));
            else if (sel < 90) cur = 4'(((int'(cur) >> 1) | (int'(cur) << 3)) & 15);
            else if (sel < 97) cur = 4'($urandom_range(0, 15));
            drive(cur, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
            if ($countones(cur) != 1) cur = 4'b0001 << $urandom_range(0, 3);
        end

        // Asynchronous reset while locked
        cur = 4'b1000;
        drive(cur, 1'b0);
        rotate_n(8);
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1 check("async_reset", dut_obs(), '0);
        repeat (2) @(negedge clk);

        // Relock, then clear coincident with a bad step
        drive(cur, 1'b0);
        rotate_n(6);
        drive(4'b1111, 1'b1);
        rotate_n(3);

        @(posedge clk);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
